fetch_sequencer: RTL

Instruction-fetch and sequencing stage of the CPU, directly upstream of the instruction decoder. It owns the program counter (PC), the instruction register (IR) and the 2-bit machine-cycle state (fetch / exec1 / exec2) that the decoder consumes. It addresses instruction RAM, latches the fetched word, and advances, redirects or halts the PC under control of the decoder's `pc_sload`, `sm_extra` and `stop` signals.

---
 rtl/fetch_sequencer.sv | 111 +++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_sequencer: owns PC, IR and the FETCH/EXEC1/EXEC2/HALT cycle    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fetch_sequencer #(
  parameter int                    ADDR_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [15:0]           instr_rdata,
  input  logic                  pc_sload,
  input  logic [ADDR_WIDTH-1:0] jump_target,
  input  logic                  sm_extra,
  input  logic                  stop,
  input  logic                  resume,
  output logic [ADDR_WIDTH-1:0] instr_addr,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [15:0]           instruction,
  output logic [1:0]            state,
  output logic                  ir_en,
  output logic                  halted,
  output logic [15:0]           retired
);

  localparam logic [1:0] c_st_fetch = 2'b00;
  localparam logic [1:0] c_st_exec1 = 2'b10;
  localparam logic [1:0] c_st_exec2 = 2'b01;
  localparam logic [1:0] c_st_halt  = 2'b11;

  logic [1:0]            r_state;
  logic [1:0]            w_state_next;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [15:0]           r_ir;
  logic [15:0]           r_retired;
  logic                  w_ir_en;
  logic                  w_halted;
  logic                  w_pc_load;
  logic                  w_retire;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_st_fetch;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_fetch: w_state_next = stop ? c_st_halt : c_st_exec1;
      c_st_exec1: begin
        if (stop)          w_state_next = c_st_halt;
        else if (sm_extra) w_state_next = c_st_exec2;
        else               w_state_next = c_st_fetch;
      end
      c_st_exec2: w_state_next = stop ? c_st_halt : c_st_fetch;
      default:    w_state_next = (resume && !stop) ? c_st_fetch : c_st_halt;
    endcase
  end

  // An instruction completes whenever an execute phase leaves for anything but EXEC2.
  always_comb begin
    w_ir_en   = 1'b0;
    w_halted  = 1'b0;
    w_pc_load = 1'b0;
    w_retire  = 1'b0;
    case (r_state)
      c_st_fetch: w_ir_en = !stop;
      c_st_exec1: begin
        w_pc_load = pc_sload;
        w_retire  = stop || !sm_extra;
      end
      c_st_exec2: begin
        w_pc_load = pc_sload;
        w_retire  = 1'b1;
      end
      default:    w_halted = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pc      <= RESET_PC;
      r_ir      <= 16'h0000;
      r_retired <= 16'h0000;
    end else begin
      if (w_ir_en) begin
        r_ir <= instr_rdata;
        r_pc <= r_pc + ADDR_WIDTH'(1);
      end else if (w_pc_load) begin
        r_pc <= jump_target;
      end
      if (w_retire) begin
        r_retired <= r_retired + 16'd1;
      end
    end
  end

  assign instr_addr  = r_pc;
  assign pc          = r_pc;
  assign instruction = r_ir;
  assign state       = r_state;
  assign ir_en       = w_ir_en;
  assign halted      = w_halted;
  assign retired     = r_retired;

endmodule
`default_nettype wire
